// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable frame-based serial pattern detector.
// Software loads a pattern, a pattern length and a frame length, then pulses
// start. The block scans exactly cfg_nbits valid bits, counts overlapping
// matches with a saturating counter, and pulses done at the end of the frame.
module seq_det_ctrl #(
  parameter  int PAT_W  = 8,
  parameter  int LEN_W  = 16,
  parameter  int CNT_W  = 8,
  localparam int PLEN_W = $clog2(PAT_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [PLEN_W-1:0] cfg_plen,
  input  logic [LEN_W-1:0]  cfg_nbits,
  input  logic              start,
  input  logic              x,
  input  logic              x_valid,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              overflow,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PLEN_W-1:0]  plen_q, plen_d;
  logic [LEN_W-1:0]   nbits_q, nbits_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [PLEN_W-1:0]  fill_q, fill_d;
  logic [LEN_W-1:0]   bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Values a start in this cycle must use: a simultaneous cfg_we wins.
  logic [PLEN_W-1:0]  plen_eff;
  logic [LEN_W-1:0]   nbits_eff;
  logic               cfg_legal;

  // Shifted history, saturating fill and the match decision for a valid bit.
  logic [PAT_W-1:0]   hist_new;
  logic [PLEN_W-1:0]  fill_new;
  logic [PAT_W-1:0]   pat_mask;
  logic               hit;

  assign plen_eff  = cfg_we ? cfg_plen  : plen_q;
  assign nbits_eff = cfg_we ? cfg_nbits : nbits_q;
  assign cfg_legal = (plen_eff != '0) && (plen_eff <= PLEN_W'(PAT_W)) && (nbits_eff != '0);

  assign hist_new = {hist_q[PAT_W-2:0], x};
  assign fill_new = (fill_q == PLEN_W'(PAT_W)) ? fill_q : fill_q + PLEN_W'(1);

  // Mask selecting the low plen bits of history/pattern for comparison.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    pat_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      pat_mask[i] = (i < int'(plen_q));
    end
  end

  assign hit = (((hist_new ^ pat_q) & pat_mask) == '0) && (fill_new >= plen_q);

  // Next-state and next-output logic of the IDLE/RUN/DONE controller.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    plen_d   = plen_q;
    nbits_d  = nbits_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    bitcnt_d = bitcnt_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    match_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          pat_d   = cfg_pattern;
          plen_d  = cfg_plen;
          nbits_d = cfg_nbits;
        end
        if (start) begin
          if (cfg_legal) begin
            state_d  = S_RUN;
            hist_d   = '0;
            fill_d   = '0;
            bitcnt_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (x_valid) begin
          hist_d   = hist_new;
          fill_d   = fill_new;
          bitcnt_d = bitcnt_q + LEN_W'(1);
          if (hit) begin
            match_d = 1'b1;
            if (cnt_q == '1) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (bitcnt_d == nbits_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state, shadow config, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      plen_q   <= '0;
      nbits_q  <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      pat_q    <= pat_d;
      plen_q   <= plen_d;
      nbits_q  <= nbits_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      match_q  <= match_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign overflow  = ovf_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule
